// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: captures the decode bundle into EX,
// inserts one bubble per load-use hazard, squashes on EX redirects, and counts both events.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_d,
  input  logic             regwrite_d,
  input  logic [1:0]       resultsrc_d,
  input  logic             memwrite_d,
  input  logic             jump_d,
  input  logic             branch_d,
  input  logic [2:0]       alucontrol_d,
  input  logic             alusrc_d,
  input  logic             use_rs1_d,
  input  logic             use_rs2_d,
  input  logic [XLEN-1:0]  rd1_d,
  input  logic [XLEN-1:0]  rd2_d,
  input  logic [XLEN-1:0]  immext_d,
  input  logic [XLEN-1:0]  pc_d,
  input  logic [XLEN-1:0]  pcplus4_d,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_d,
  input  logic             flush_e,
  output logic             valid_e,
  output logic             regwrite_e,
  output logic [1:0]       resultsrc_e,
  output logic             memwrite_e,
  output logic             jump_e,
  output logic             branch_e,
  output logic [2:0]       alucontrol_e,
  output logic             alusrc_e,
  output logic [XLEN-1:0]  rd1_e,
  output logic [XLEN-1:0]  rd2_e,
  output logic [XLEN-1:0]  immext_e,
  output logic [XLEN-1:0]  pc_e,
  output logic [XLEN-1:0]  pcplus4_e,
  output logic [4:0]       rs1_e,
  output logic [4:0]       rs2_e,
  output logic [4:0]       rd_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic lu;
  logic load_bubble;

  // Load in EX whose (nonzero) destination is read by the live decode instruction.
  always_comb begin
    lu = valid_e & (resultsrc_e == 2'b01) & (rd_e != 5'd0) & valid_d &
         ((use_rs1_d & (rs1_d == rd_e)) | (use_rs2_d & (rs2_d == rd_e)));
  end

  // Stall contract: while stall_f/stall_d are high, fetch and decode hold their
  // registers, so the same decode bundle is presented again on the next cycle.
  assign load_bubble = lu & ~flush_e & ~reset;
  assign stall_f     = load_bubble;
  assign stall_d     = load_bubble;

  always_ff @(posedge clk) begin
    if (reset || flush_e || lu) begin
      valid_e      <= 1'b0;
      regwrite_e   <= 1'b0;
      resultsrc_e  <= 2'b00;
      memwrite_e   <= 1'b0;
      jump_e       <= 1'b0;
      branch_e     <= 1'b0;
      alucontrol_e <= 3'b000;
      alusrc_e     <= 1'b0;
      rd1_e        <= '0;
      rd2_e        <= '0;
      immext_e     <= '0;
      pc_e         <= '0;
      pcplus4_e    <= '0;
      rs1_e        <= 5'd0;
      rs2_e        <= 5'd0;
      rd_e         <= 5'd0;
    end else begin
      // Architectural side effects are gated by valid; data rides along regardless.
      valid_e      <= valid_d;
      regwrite_e   <= regwrite_d & valid_d;
      resultsrc_e  <= resultsrc_d;
      memwrite_e   <= memwrite_d & valid_d;
      jump_e       <= jump_d & valid_d;
      branch_e     <= branch_d & valid_d;
      alucontrol_e <= alucontrol_d;
      alusrc_e     <= alusrc_d;
      rd1_e        <= rd1_d;
      rd2_e        <= rd2_d;
      immext_e     <= immext_d;
      pc_e         <= pc_d;
      pcplus4_e    <= pcplus4_d;
      rs1_e        <= rs1_d;
      rs2_e        <= rs2_d;
      rd_e         <= rd_d;
    end

    if (reset) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (flush_e) begin
      if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
    end else if (lu) begin
      if (bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by random traffic, checked against
// an expected-EX model; a second instance with 2-bit counters exercises saturation.
module tb_id_ex_stage;

  localparam int XLEN = 32;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic        memwrite;
    logic        jump;
    logic        branch;
    logic [2:0]  alucontrol;
    logic        alusrc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } ex_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic            valid_d, regwrite_d, memwrite_d, jump_d, branch_d, alusrc_d;
  logic [1:0]      resultsrc_d;
  logic [2:0]      alucontrol_d;
  logic            use_rs1_d, use_rs2_d, flush_e;
  logic [XLEN-1:0] rd1_d, rd2_d, immext_d, pc_d, pcplus4_d;
  logic [4:0]      rs1_d, rs2_d, rd_d;

  logic            valid_e, regwrite_e, memwrite_e, jump_e, branch_e, alusrc_e;
  logic [1:0]      resultsrc_e;
  logic [2:0]      alucontrol_e;
  logic [XLEN-1:0] rd1_e, rd2_e, immext_e, pc_e, pcplus4_e;
  logic [4:0]      rs1_e, rs2_e, rd_e;
  logic            stall_f, stall_d;
  logic [15:0]     bubble_cnt, flush_cnt;

  logic            s_valid_e, s_regwrite_e, s_memwrite_e, s_jump_e, s_branch_e, s_alusrc_e;
  logic [1:0]      s_resultsrc_e;
  logic [2:0]      s_alucontrol_e;
  logic [XLEN-1:0] s_rd1_e, s_rd2_e, s_immext_e, s_pc_e, s_pcplus4_e;
  logic [4:0]      s_rs1_e, s_rs2_e, s_rd_e;
  logic            s_stall_f, s_stall_d;
  logic [1:0]      s_bubble_cnt, s_flush_cnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d), .regwrite_d(regwrite_d),
    .resultsrc_d(resultsrc_d), .memwrite_d(memwrite_d), .jump_d(jump_d),
    .branch_d(branch_d), .alucontrol_d(alucontrol_d), .alusrc_d(alusrc_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .immext_d(immext_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d), .rs1_d(rs1_d),
    .rs2_d(rs2_d), .rd_d(rd_d), .flush_e(flush_e), .valid_e(valid_e),
    .regwrite_e(regwrite_e), .resultsrc_e(resultsrc_e), .memwrite_e(memwrite_e),
    .jump_e(jump_e), .branch_e(branch_e), .alucontrol_e(alucontrol_e),
    .alusrc_e(alusrc_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .immext_e(immext_e),
    .pc_e(pc_e), .pcplus4_e(pcplus4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .stall_f(stall_f), .stall_d(stall_d), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.XLEN(XLEN), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .valid_d(valid_d), .regwrite_d(regwrite_d),
    .resultsrc_d(resultsrc_d), .memwrite_d(memwrite_d), .jump_d(jump_d),
    .branch_d(branch_d), .alucontrol_d(alucontrol_d), .alusrc_d(alusrc_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .immext_d(immext_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d), .rs1_d(rs1_d),
    .rs2_d(rs2_d), .rd_d(rd_d), .flush_e(flush_e), .valid_e(s_valid_e),
    .regwrite_e(s_regwrite_e), .resultsrc_e(s_resultsrc_e), .memwrite_e(s_memwrite_e),
    .jump_e(s_jump_e), .branch_e(s_branch_e), .alucontrol_e(s_alucontrol_e),
    .alusrc_e(s_alusrc_e), .rd1_e(s_rd1_e), .rd2_e(s_rd2_e), .immext_e(s_immext_e),
    .pc_e(s_pc_e), .pcplus4_e(s_pcplus4_e), .rs1_e(s_rs1_e), .rs2_e(s_rs2_e),
    .rd_e(s_rd_e), .stall_f(s_stall_f), .stall_d(s_stall_d),
    .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
  );

  // reference model state: what EX should hold, and how many events have happened
  ex_t m;
  int  bubbles = 0;
  int  flushes = 0;
  int  n_cmp   = 0;
  int  n_bad   = 0;
  logic last_stall = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // A live load in EX writing a real register that the live decode instruction reads.
  function automatic bit model_hazard();
    bit reads_it;
    reads_it = (use_rs1_d && rs1_d == m.rd) || (use_rs2_d && rs2_d == m.rd);
    return m.valid && m.resultsrc == 2'b01 && m.rd != 5'd0 && valid_d && reads_it;
  endfunction

  function automatic bit model_stall();
    return model_hazard() && !flush_e && !reset;
  endfunction

  task automatic model_step();
    bit hz;
    hz = model_hazard();
    if (reset) begin
      m = '0; bubbles = 0; flushes = 0;
    end else if (flush_e) begin
      m = '0; flushes++;
    end else if (hz) begin
      m = '0; bubbles++;
    end else begin
      m = '{valid: valid_d, regwrite: regwrite_d && valid_d, resultsrc: resultsrc_d,
            memwrite: memwrite_d && valid_d, jump: jump_d && valid_d,
            branch: branch_d && valid_d, alucontrol: alucontrol_d, alusrc: alusrc_d,
            rd1: rd1_d, rd2: rd2_d, imm: immext_d, pc: pc_d, pc4: pcplus4_d,
            rs1: rs1_d, rs2: rs2_d, rd: rd_d};
    end
  endtask

  task automatic check_outputs();
    check("ctrl", {valid_e, regwrite_e, resultsrc_e, memwrite_e, jump_e, branch_e, alucontrol_e, alusrc_e},
          {m.valid, m.regwrite, m.resultsrc, m.memwrite, m.jump, m.branch, m.alucontrol, m.alusrc});
    check("rd1_e", rd1_e, m.rd1);
    check("rd2_e", rd2_e, m.rd2);
    check("immext_e", immext_e, m.imm);
    check("pc_e", {pc_e, pcplus4_e}, {m.pc, m.pc4});
    check("idx_e", {rs1_e, rs2_e, rd_e}, {m.rs1, m.rs2, m.rd});
    check("bubble_cnt", bubble_cnt, sat(bubbles, 65535));
    check("flush_cnt", flush_cnt, sat(flushes, 65535));
    check("s_bubble_cnt", s_bubble_cnt, sat(bubbles, 3));
    check("s_flush_cnt", s_flush_cnt, sat(flushes, 3));
    check("s_ctrl_valid", {s_valid_e, s_rd_e}, {m.valid, m.rd});
  endtask

  // driver: inputs are already applied; check stalls, advance model, check EX after the edge
  task automatic cycle();
    #1;
    last_stall = model_stall();
    check("stall_f", stall_f, last_stall);
    check("stall_d", stall_d, last_stall);
    check("s_stall", {s_stall_f, s_stall_d}, {last_stall, last_stall});
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic peek_stall(input string tag, input logic expv);
    #1;
    check(tag, {stall_f, stall_d}, {expv, expv});
  endtask

  task automatic clear_d();
    {valid_d, regwrite_d, memwrite_d, jump_d, branch_d, alusrc_d} = '0;
    resultsrc_d = 2'b00; alucontrol_d = 3'b000;
    use_rs1_d = 1'b0; use_rs2_d = 1'b0; flush_e = 1'b0;
    rd1_d = '0; rd2_d = '0; immext_d = '0; pc_d = '0; pcplus4_d = '0;
    rs1_d = 5'd0; rs2_d = 5'd0; rd_d = 5'd0;
  endtask

  task automatic load_to(input logic [4:0] r);
    clear_d();
    valid_d = 1'b1; regwrite_d = 1'b1; resultsrc_d = 2'b01; rd_d = r;
    rd1_d = 32'h1000; immext_d = 32'h4;
  endtask

  task automatic rand_d();
    valid_d      = ($urandom_range(0, 7) != 0);
    regwrite_d   = $urandom_range(0, 1);
    resultsrc_d  = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
    memwrite_d   = $urandom_range(0, 1);
    jump_d       = $urandom_range(0, 1);
    branch_d     = $urandom_range(0, 1);
    alucontrol_d = 3'($urandom_range(0, 7));
    alusrc_d     = $urandom_range(0, 1);
    use_rs1_d    = $urandom_range(0, 1);
    use_rs2_d    = $urandom_range(0, 1);
    rd1_d        = $urandom;
    rd2_d        = $urandom;
    immext_d     = $urandom;
    pc_d         = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 255) * 4);
    pcplus4_d    = pc_d + 32'd4;
    rs1_d        = 5'($urandom_range(0, 5));
    rs2_d        = 5'($urandom_range(0, 5));
    rd_d         = 5'($urandom_range(0, 5));
  endtask

  initial begin
    clear_d();

    // 1: reset, then normal capture
    reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    valid_d = 1'b1; regwrite_d = 1'b1; alucontrol_d = 3'b010; rd1_d = 32'h11; rd_d = 5'd5;
    peek_stall("t1_stall", 1'b0);
    cycle();
    check("t1_capture", {regwrite_e, alucontrol_e, rd1_e, rd_e}, {1'b1, 3'b010, 32'h11, 5'd5});

    // 2: load-use on rs1 gives exactly one bubble, then the held instruction
    load_to(5'd7);
    cycle();
    clear_d();
    valid_d = 1'b1; regwrite_d = 1'b1; use_rs1_d = 1'b1; rs1_d = 5'd7; rd_d = 5'd8; rd2_d = 32'h22;
    peek_stall("t2_stall_on", 1'b1);
    cycle();
    check("t2_bubble", {valid_e, regwrite_e, rd_e, bubble_cnt}, {1'b0, 1'b0, 5'd0, 16'd1});
    peek_stall("t2_stall_off", 1'b0);
    cycle();
    check("t2_held", {valid_e, rs1_e, rd_e, rd2_e}, {1'b1, 5'd7, 5'd8, 32'h22});

    // 3: load to x0 never stalls
    load_to(5'd0);
    cycle();
    clear_d();
    valid_d = 1'b1; use_rs2_d = 1'b1; rs2_d = 5'd0; rd_d = 5'd9;
    peek_stall("t3_stall", 1'b0);
    cycle();
    check("t3_capture", {valid_e, rd_e, bubble_cnt}, {1'b1, 5'd9, 16'd1});

    // 4: flush beats a concurrent load-use hazard
    load_to(5'd4);
    cycle();
    clear_d();
    valid_d = 1'b1; memwrite_d = 1'b1; use_rs1_d = 1'b1; rs1_d = 5'd4; rd1_d = 32'hdead;
    flush_e = 1'b1;
    peek_stall("t4_stall", 1'b0);
    cycle();
    check("t4_flush", {memwrite_e, valid_e, rd1_e, flush_cnt, bubble_cnt}, {1'b0, 1'b0, 32'h0, 16'd1, 16'd1});
    flush_e = 1'b0;

    // 5: saturation of the 2-bit counter after a fresh reset
    clear_d();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      load_to(5'd3);
      cycle();
      clear_d();
      valid_d = 1'b1; use_rs2_d = 1'b1; rs2_d = 5'd3; rd_d = 5'd10;
      cycle();
      cycle();
      if (k >= 3) check("t5_sat", s_bubble_cnt, 2'd3);
    end
    check("t5_wide", bubble_cnt, 16'd5);

    // 6: reset during a stall drops the stall and clears everything
    load_to(5'd6);
    cycle();
    clear_d();
    valid_d = 1'b1; use_rs1_d = 1'b1; rs1_d = 5'd6; rd_d = 5'd11;
    reset = 1'b1;
    peek_stall("t6_stall", 1'b0);
    cycle();
    reset = 1'b0;
    check("t6_clear", {valid_e, rd_e, bubble_cnt, flush_cnt}, {1'b0, 5'd0, 16'd0, 16'd0});

    // random traffic; a stalled decode bundle is held, as upstream would do
    clear_d();
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) rand_d();
      flush_e = ($urandom_range(0, 7) == 0);
      reset   = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
